ecc_link_ctrl: RTL and testbench

- Sequences the shared 5-bit→10-bit SEC-DED codec between two requesters, with round-robin arbitration.
- For each request: drives the codec with the data word and the error-injection mask, then samples the codec's error index and parity flag.
- Classifies the outcome, retries the word on uncorrectable errors, and returns one status response per request.
- Sits between the requester front-ends and the codec instance; it keeps running counts of corrected and uncorrectable events.

---
 rtl/ecc_link_ctrl_if.sv | 35 +++
 rtl/ecc_link_ctrl.sv | 136 +++++++++++++
 tb/tb_ecc_link_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_link_ctrl_if.sv
// ecc_link_ctrl_if: requester, codec and response bundle around ecc_link_ctrl.
// The controller uses the slave modport; requesters, codec and consumer use master.
interface ecc_link_ctrl_if;
  logic       req0_valid;
  logic       req1_valid;
  logic [4:0] req0_data;
  logic [4:0] req1_data;
  logic [9:0] req0_err;
  logic [9:0] req1_err;
  logic       req0_ready;
  logic       req1_ready;
  logic [4:0] codec_raw;
  logic [9:0] codec_err;
  logic [3:0] codec_index;
  logic       codec_multi;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [1:0] rsp_status;
  logic [3:0] rsp_index;

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, req0_err, req1_err,
    input  codec_index, codec_multi, rsp_ready,
    output req0_ready, req1_ready, codec_raw, codec_err,
    output rsp_valid, rsp_id, rsp_status, rsp_index
  );

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, req0_err, req1_err,
    output codec_index, codec_multi, rsp_ready,
    input  req0_ready, req1_ready, codec_raw, codec_err,
    input  rsp_valid, rsp_id, rsp_status, rsp_index
  );
endinterface

// File: rtl/ecc_link_ctrl.sv
// ecc_link_ctrl: round-robin sequencer sharing one 5->10 bit SEC-DED codec between two requesters.
// Define ECC_RETRY_EN to relaunch a word with a cleared mask after a DOUBLE result (up to MAX_RETRY times).
module ecc_link_ctrl #(
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  ecc_link_ctrl_if.slave   bus,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, LAUNCH, CAPTURE, RESP} state_t;

  localparam logic [1:0] ST_CLEAN     = 2'b00;
  localparam logic [1:0] ST_CORRECTED = 2'b01;
  localparam logic [1:0] ST_FAILED    = 2'b10;
  localparam logic [1:0] ST_RECOVERED = 2'b11;

  state_t state, state_nxt;
  logic   last;
  logic   grant0, grant1, retry_go;
  logic   is_single, is_double;
  logic   can_retry, earlier_double;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Odd overall parity means one flip (index 0 is the parity bit itself); even parity with a
  // nonzero syndrome means two flips.
  assign is_single = bus.codec_multi;
  assign is_double = !bus.codec_multi && (bus.codec_index != 4'd0);

`ifdef ECC_RETRY_EN
  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);

  logic [1:0] retry;
  logic       had_double;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry      <= '0;
      had_double <= 1'b0;
    end else if (grant0 || grant1) begin
      retry      <= '0;
      had_double <= 1'b0;
    end else if (retry_go) begin
      retry      <= retry + 1'b1;
      had_double <= 1'b1;
    end
  end

  assign can_retry      = retry < RETRY_LIMIT;
  assign earlier_double = had_double;
`else
  logic unused_max_retry;
  assign unused_max_retry = ^MAX_RETRY;
  assign can_retry        = 1'b0;
  assign earlier_double   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // On a tie the requester that was not served last wins.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    retry_go  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          grant1    = bus.req1_valid && (!bus.req0_valid || !last);
          grant0    = !grant1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH:  state_nxt = CAPTURE;
      CAPTURE: begin
        if (is_double && can_retry) begin
          retry_go  = 1'b1;
          state_nxt = LAUNCH;
        end else begin
          state_nxt = RESP;
        end
      end
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The codec input registers double as the latched request, so they hold between requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.codec_raw  <= '0;
      bus.codec_err  <= '0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_status <= ST_CLEAN;
      bus.rsp_index  <= '0;
      cnt_single     <= '0;
      cnt_double     <= '0;
      last           <= 1'b1;
    end else begin
      if (grant0 || grant1) begin
        bus.codec_raw <= grant1 ? bus.req1_data : bus.req0_data;
        bus.codec_err <= grant1 ? bus.req1_err : bus.req0_err;
        bus.rsp_id    <= grant1;
      end
      if (retry_go) begin
        bus.codec_err <= '0;
        cnt_double    <= sat_inc(cnt_double);
      end else if (state == CAPTURE) begin
        bus.rsp_index <= bus.codec_index;
        if (is_double) begin
          bus.rsp_status <= ST_FAILED;
          cnt_double     <= sat_inc(cnt_double);
        end else begin
          if (is_single) cnt_single <= sat_inc(cnt_single);
          bus.rsp_status <= earlier_double ? ST_RECOVERED :
                            (is_single ? ST_CORRECTED : ST_CLEAN);
        end
      end
      if (state == RESP && bus.rsp_ready) last <= bus.rsp_id;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = (state == RESP);
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_ecc_link_ctrl.sv
// tb_ecc_link_ctrl: directed and random requests against ecc_link_ctrl with a stand-in codec
// and a result model derived from the classification rules.
module tb_ecc_link_ctrl;
  localparam int MAX_RETRY = 2;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef ECC_RETRY_EN
  localparam int RETRIES = MAX_RETRY;
`else
  localparam int RETRIES = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] cnt_single;
  logic [CNT_W-1:0] cnt_double;
  logic             busy;
  int               total = 0;
  int               bad = 0;
  logic             exp_last;
  int               exp_single;
  int               exp_double;

  ecc_link_ctrl_if bus();

  ecc_link_ctrl #(.MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cnt_single (cnt_single),
    .cnt_double (cnt_double),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] syndrome(input logic [9:0] m);
    logic [3:0] s;
    s = 4'd0;
    for (int k = 1; k < 10; k++) if (m[k]) s ^= 4'(k);
    return s;
  endfunction

  // Codec stand-in: a flip at codeword position k moves the syndrome by k; every flip toggles parity.
  always @(posedge clk) begin
    bus.codec_index <= syndrome(bus.codec_err);
    bus.codec_multi <= ^bus.codec_err;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] d0, input logic [9:0] e0,
                               input logic v1, input logic [4:0] d1, input logic [9:0] e1);
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req0_err   = e0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    bus.req1_err   = e1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".ctl"}, {bus.req1_ready, bus.req0_ready, bus.rsp_valid, busy}, 0);
    checkOutput({tag, ".rsp"}, {bus.rsp_id, bus.rsp_status, bus.rsp_index}, 0);
    checkOutput({tag, ".codec"}, {bus.codec_raw, bus.codec_err}, 0);
    checkOutput({tag, ".cnt"}, {cnt_single, cnt_double}, 0);
  endtask

  // A retry relaunches the word with an empty mask, so one retry always ends clean with index 0.
  task automatic predict(input logic [9:0] e, output logic [1:0] st, output logic [3:0] idx,
                         output int attempts, output int ds, output int dd);
    logic [3:0] s;
    s = syndrome(e);
    ds = 0; dd = 0; attempts = 1; idx = s;
    if (^e) begin
      st = 2'b01; ds = 1;
    end else if (s == 4'd0) begin
      st = 2'b00;
    end else if (RETRIES > 0) begin
      st = 2'b11; dd = 1; attempts = 2; idx = 4'd0;
    end else begin
      st = 2'b10; dd = 1;
    end
  endtask

  function automatic int sat_add(input int v, input int d);
    return (v + d > CNT_MAX) ? CNT_MAX : v + d;
  endfunction

  function automatic logic [9:0] randMask();
    int r, b1, b2;
    logic [9:0] m;
    r = $urandom_range(0, 9);
    m = 10'd0;
    if (r >= 3 && r <= 6) begin
      m[$urandom_range(0, 9)] = 1'b1;
    end else if (r >= 7 && r <= 8) begin
      b1 = $urandom_range(0, 9);
      b2 = (b1 + $urandom_range(1, 9)) % 10;
      m[b1] = 1'b1;
      m[b2] = 1'b1;
    end else if (r == 9) begin
      m = 10'($urandom);
    end
    return m;
  endfunction

  // One request from an idle controller with rsp_ready high; keep leaves the valids asserted.
  task automatic serveOne(input string tag, input logic v0, input logic [4:0] d0, input logic [9:0] e0,
                          input logic v1, input logic [4:0] d1, input logic [9:0] e1, input bit keep);
    logic       who;
    logic [4:0] d;
    logic [9:0] e;
    logic [1:0] st;
    logic [3:0] idx;
    int         att, ds, dd, n;
    bit         seen, stray;
    who = (v0 && v1) ? !exp_last : v1;
    d   = who ? d1 : d0;
    e   = who ? e1 : e0;
    predict(e, st, idx, att, ds, dd);
    @(negedge clk);
    applyStimulus(v0, d0, e0, v1, d1, e1);
    #1;
    checkOutput({tag, ".grant"}, {bus.req1_ready, bus.req0_ready}, who ? 2'b10 : 2'b01);
    seen = 0; stray = 0; n = 0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid) begin
        seen = 1;
      end else begin
        if (bus.req0_ready || bus.req1_ready) stray = 1;
        if (n % 2 == 1)
          checkOutput({tag, ".launch"}, {bus.codec_raw, bus.codec_err}, {d, (n == 1) ? e : 10'd0});
      end
      if (!keep && n == 1) applyStimulus(0, 5'd0, 10'd0, 0, 5'd0, 10'd0);
    end
    checkOutput({tag, ".resp_seen"}, seen, 1);
    if (seen) begin
      exp_single = sat_add(exp_single, ds);
      exp_double = sat_add(exp_double, dd);
      checkOutput({tag, ".latency"}, n, 1 + 2 * att);
      checkOutput({tag, ".id"}, bus.rsp_id, who);
      checkOutput({tag, ".status"}, bus.rsp_status, st);
      checkOutput({tag, ".index"}, bus.rsp_index, idx);
      checkOutput({tag, ".cnt_single"}, cnt_single, exp_single);
      checkOutput({tag, ".cnt_double"}, cnt_double, exp_double);
      checkOutput({tag, ".busy_ready"}, stray, 0);
      exp_last = who;
    end
  endtask

  initial begin
    logic       stable, anyready, who;
    logic [9:0] re0, re1;
    logic       rv0, rv1;
    applyStimulus(0, 5'd0, 10'd0, 0, 5'd0, 10'd0);
    bus.rsp_ready = 1'b1;
    exp_last = 1'b1; exp_single = 0; exp_double = 0;
    repeat (2) @(negedge clk);
    checkResetState("por");
    rst = 1'b1;

    serveOne("clean",  1, 5'b10110, 10'd0, 0, 5'd0, 10'd0, 0);
    serveOne("single", 0, 5'd0, 10'd0, 1, 5'b01101, 10'b0000010000, 0);
    serveOne("double", 1, 5'b00111, 10'b0000000110, 0, 5'd0, 10'd0, 0);
    for (int i = 0; i < 4; i++)
      serveOne("arb", 1, 5'h0A, 10'd0, 1, 5'h15, 10'b0000001000, 1);
    applyStimulus(0, 5'd0, 10'd0, 0, 5'd0, 10'd0);

    // Response stalled by the consumer while both requesters wait.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    applyStimulus(1, 5'b11001, 10'b0000000001, 0, 5'd0, 10'd0);
    @(negedge clk);
    applyStimulus(0, 5'd0, 10'd0, 0, 5'd0, 10'd0);
    repeat (2) @(negedge clk);
    exp_single = sat_add(exp_single, 1);
    checkOutput("bp.valid", bus.rsp_valid, 1);
    checkOutput("bp.resp", {bus.rsp_id, bus.rsp_status, bus.rsp_index}, {1'b0, 2'b01, 4'd0});
    applyStimulus(1, 5'b11111, 10'b1000000000, 1, 5'b11111, 10'b1000000000);
    stable = 1'b1; anyready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.rsp_valid || {bus.rsp_id, bus.rsp_status, bus.rsp_index} !== {1'b0, 2'b01, 4'd0})
        stable = 1'b0;
      if (bus.req0_ready || bus.req1_ready) anyready = 1'b1;
    end
    checkOutput("bp.stable", stable, 1);
    checkOutput("bp.no_grant", anyready, 0);
    checkOutput("bp.cnt_single", cnt_single, exp_single);
    bus.rsp_ready = 1'b1;
    exp_last = 1'b0;

    // Grant, then pull reset in the middle of LAUNCH.
    who = !exp_last;
    @(negedge clk);
    checkOutput("rst.grant", {bus.req1_ready, bus.req0_ready}, who ? 2'b10 : 2'b01);
    @(negedge clk);
    checkOutput("rst.launch", {busy, bus.codec_raw}, {1'b1, 5'b11111});
    rst = 1'b0;
    applyStimulus(0, 5'd0, 10'd0, 0, 5'd0, 10'd0);
    #1;
    checkResetState("mid");
    @(negedge clk);
    rst = 1'b1;
    exp_last = 1'b1; exp_single = 0; exp_double = 0;
    serveOne("after_rst", 1, 5'b00001, 10'd0, 1, 5'b00010, 10'd0, 0);

    for (int i = 0; i < 80; i++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      if (!rv0 && !rv1) rv0 = 1'b1;
      re0 = randMask();
      re1 = randMask();
      serveOne("rand", rv0, 5'($urandom), re0, rv1, 5'($urandom), re1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
